// File: rtl/demux16_collector.sv
// demux16_collector: 1:16 serial-to-parallel collector with valid/ready word output.
// Define DEMUX16_PARITY_EN for a 17-bit frame ending in an even-parity bit checked into parity_err.
module demux16_collector (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [3:0]  sel,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        parity_err
);
`ifdef DEMUX16_PARITY_EN
  localparam logic [4:0] LAST = 5'd16;
  logic [15:0] asm;
`else
  localparam logic [4:0] LAST = 5'd15;
  logic [14:0] asm;
`endif
  logic [4:0] cnt;
  logic last, acc, done;
  assign last = cnt == LAST;
  assign din_ready = !(last && dout_valid && !dout_ready);
  assign acc = din_valid && din_ready;
  assign done = acc && last && !clr;
  assign sel = cnt[3:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      asm <= '0;
    end else if (clr) begin
      cnt <= '0;
      asm <= '0;
    end else if (acc) begin
      cnt <= last ? 5'd0 : cnt + 5'd1;
      if (!last) asm[cnt[3:0]] <= din;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout <= '0;
      dout_valid <= 1'b0;
    end else if (done) begin
`ifdef DEMUX16_PARITY_EN
      dout <= asm;
`else
      dout <= {din, asm};
`endif
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
`ifdef DEMUX16_PARITY_EN
  // parity status travels with the word it describes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity_err <= 1'b0;
    else if (done) parity_err <= ^{asm, din};
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_demux16_collector.sv
// tb_demux16_collector: directed table-driven bench for demux16_collector.
module tb_demux16_collector;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, din = 1'b0, din_valid = 1'b0, dout_ready = 1'b1;
  logic din_ready, dout_valid, parity_err;
  logic [3:0] sel;
  logic [15:0] dout;
  int checks = 0, errors = 0;
`ifdef DEMUX16_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  demux16_collector dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sel(sel), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_dout;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [15:0] w, input logic p, input int i);
    return (i < 16) ? w[i] : p;
  endfunction

  task automatic send_bit(input logic b);
    int n = 0;
    din = b;
    din_valid = 1'b1;
    while (!din_ready && n < 50) begin
      step();
      n++;
    end
    if (!din_ready) chk("din_ready_timeout", 0, 1);
    step();
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic p, input bit check_sel);
    for (int i = 0; i < NB; i++) begin
      if (check_sel) chk("sel_step", 32'(sel), 32'(i[3:0]));
      send_bit(fbit(w, p, i));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_din_ready"}, 32'(din_ready), 1);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_dout_valid"}, 32'(dout_valid), 0);
    chk({tag, "_parity_err"}, 32'(parity_err), 0);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 16'hA5C3};
    vecs[1] = '{16'h0000, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF};
    vecs[3] = '{16'h8001, 16'h8001};
    vecs[4] = '{16'h5A3C, 16'h5A3C};
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk_reset("reset");

    // back-to-back words with consumer always ready
    dout_ready = 1'b1;
    foreach (vecs[k]) begin
      send_word(vecs[k].word, ^vecs[k].word, 1'b1);
      chk("vec_dout", 32'(dout), 32'(vecs[k].exp_dout));
      chk("vec_valid", 32'(dout_valid), 1);
      chk("vec_sel_wrap", 32'(sel), 0);
      chk("vec_parity", 32'(parity_err), 0);
      step();
      chk("vec_drain", 32'(dout_valid), 0);
    end

    // back-pressure: second word blocks at its final slot
    dout_ready = 1'b0;
    send_word(16'h1234, ^16'h1234, 1'b0);
    chk("bp_first_valid", 32'(dout_valid), 1);
    for (int i = 0; i < NB - 1; i++) begin
      if (i == 7) chk("bp_mid_ready", 32'(din_ready), 1);
      send_bit(fbit(16'hFFFF, 1'b0, i));
    end
    din = fbit(16'hFFFF, 1'b0, NB - 1);
    din_valid = 1'b1;
    chk("bp_last_sel", 32'(sel), 32'(NB == 17 ? 0 : 15));
    chk("bp_blocked", 32'(din_ready), 0);
    step();
    chk("bp_held_dout", 32'(dout), 32'h1234);
    chk("bp_still_blocked", 32'(din_ready), 0);
    dout_ready = 1'b1;
    #1;
    chk("bp_unblocked", 32'(din_ready), 1);
    step();
    din_valid = 1'b0;
    chk("bp_swap_dout", 32'(dout), 32'hFFFF);
    chk("bp_swap_valid", 32'(dout_valid), 1);
    chk("bp_swap_sel", 32'(sel), 0);
    step();
    chk("bp_drain", 32'(dout_valid), 0);

    // gapped input: sel holds across idle cycles
    for (int i = 0; i < NB; i++) begin
      send_bit(fbit(16'h8001, 1'b0, i));
      if (i == 4) begin
        step();
        chk("gap_sel_hold", 32'(sel), 5);
      end
    end
    chk("gap_dout", 32'(dout), 32'h8001);
    chk("gap_valid", 32'(dout_valid), 1);
    step();

    // clr at slot 7 beats a simultaneous accept
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    chk("clr_pre_sel", 32'(sel), 7);
    clr = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    step();
    clr = 1'b0;
    din_valid = 1'b0;
    chk("clr_sel", 32'(sel), 0);
    chk("clr_valid_untouched", 32'(dout_valid), 0);
    send_word(16'h00F0, 1'b0, 1'b0);
    chk("clr_dout", 32'(dout), 32'h00F0);
    step();

    // asynchronous reset mid-word with a pending output
    dout_ready = 1'b0;
    send_word(16'h1234, ^16'h1234, 1'b0);
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    chk("arst_pre_sel", 32'(sel), 9);
    chk("arst_pre_valid", 32'(dout_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_reset("arst_after");

`ifdef DEMUX16_PARITY_EN
    dout_ready = 1'b1;
    send_word(16'h0003, 1'b0, 1'b0);
    chk("par_ok_dout", 32'(dout), 32'h0003);
    chk("par_ok", 32'(parity_err), 0);
    send_word(16'h0003, 1'b1, 1'b0);
    chk("par_bad", 32'(parity_err), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
